// File: rtl/ds_arb_pkg.sv
// Shared types and constants for the delta-sigma adder arbiter.
package ds_arb_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int MAX_NUM_REQ = 8;
  localparam int PTR_W       = $clog2(MAX_NUM_REQ);

  typedef logic [WIDTH_DEF-1:0] word_t;
  typedef logic [3:0]           starve_cnt_t;

endpackage

// File: rtl/ds_rr_picker.sv
// Rotate-priority picker over the auxiliary requesters, searching upward from
// rr_ptr and wrapping from NUM_REQ-1 back to 1.
module ds_rr_picker
  import ds_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:1] req_aux,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:1] pick,
  output logic               found
);

  int   idx_s;
  logic hit_s;

  // First requesting index in rotated order; at most one bit of pick is set.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx_s = 0;
    hit_s = 1'b0;
    for (int i = 0; i < NUM_REQ - 1; i++) begin
      idx_s = ((int'(rr_ptr) - 1 + i) % (NUM_REQ - 1)) + 1;
      for (int j = 1; j < NUM_REQ; j++) begin
        hit_s   = !found && req_aux[j] && (j == idx_s);
        pick[j] = pick[j] | hit_s;
        found   = found | hit_s;
      end
    end
  end

endmodule

// File: rtl/ds_adder_arbiter.sv
// Time-shared registered add/subtract unit: port 0 has priority, aux ports are
// round-robin with a starvation guard. Optional clamp via DS_ARB_SATURATE_EN.
module ds_adder_arbiter
  import ds_arb_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int NUM_REQ      = 4,
  parameter int STARVE_LIMIT = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] src0,
  input  logic [NUM_REQ*WIDTH-1:0] src1,
  input  logic [NUM_REQ-1:0]       inv_src1,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]         result,
  output logic                     carry_out,
  output logic [NUM_REQ-1:0]       result_valid,
  output logic                     starve_event
);

  localparam starve_cnt_t LIMIT_C = starve_cnt_t'(STARVE_LIMIT);

  logic [NUM_REQ-1:1] pick_s;
  logic               found_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic               aux_pend_s;
  logic               aux_gnt_s;
  logic [WIDTH-1:0]   a_s;
  logic [WIDTH-1:0]   b_s;
  logic               inv_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH-1:0]   res_s;
  logic [PTR_W-1:0]   rr_hit_s;

  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic [NUM_REQ-1:0] valid_q, valid_d;
  logic               starve_q, starve_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  starve_cnt_t        cnt_q, cnt_d;

  ds_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_aux (req[NUM_REQ-1:1]),
    .rr_ptr  (rr_ptr_q),
    .pick    (pick_s),
    .found   (found_s)
  );

  // Grant decision: port 0 wins unless the starvation counter has hit its limit.
  always_comb begin
    aux_pend_s = |req[NUM_REQ-1:1];
    if (reset) begin
      gnt_s = '0;
    end else if (req[0] && (cnt_q < LIMIT_C)) begin
      gnt_s = {{(NUM_REQ-1){1'b0}}, 1'b1};
    end else if (found_s) begin
      gnt_s = {pick_s, 1'b0};
    end else begin
      gnt_s = '0;
    end
    aux_gnt_s = |gnt_s[NUM_REQ-1:1];
  end

  // Operand mux, shared adder and next-state for every register.
  always_comb begin
    a_s      = '0;
    b_s      = '0;
    inv_s    = 1'b0;
    rr_hit_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      a_s   = a_s | (src0[k*WIDTH +: WIDTH] & {WIDTH{gnt_s[k]}});
      b_s   = b_s | (src1[k*WIDTH +: WIDTH] & {WIDTH{gnt_s[k]}});
      inv_s = inv_s | (inv_src1[k] & gnt_s[k]);
    end
    for (int k = 1; k < NUM_REQ; k++) begin
      rr_hit_s = rr_hit_s | ({PTR_W{gnt_s[k]}} &
                 ((k == NUM_REQ - 1) ? PTR_W'(1) : PTR_W'(k + 1)));
    end
    sum_s = {1'b0, a_s} + {1'b0, (inv_s ? ~b_s : b_s)} + {{WIDTH{1'b0}}, inv_s};
`ifdef DS_ARB_SATURATE_EN
    if (sum_s[WIDTH] && !inv_s) begin
      res_s = '1;
    end else if (!sum_s[WIDTH] && inv_s) begin
      res_s = '0;
    end else begin
      res_s = sum_s[WIDTH-1:0];
    end
`else
    res_s = sum_s[WIDTH-1:0];
`endif
    if (|gnt_s) begin
      result_d = res_s;
      carry_d  = sum_s[WIDTH];
    end else begin
      result_d = result_q;
      carry_d  = carry_q;
    end
    valid_d  = gnt_s;
    starve_d = aux_gnt_s && req[0] && (cnt_q >= LIMIT_C);
    rr_ptr_d = aux_gnt_s ? rr_hit_s : rr_ptr_q;
    // Counter only runs while port 0 is actually crowding out a pending aux request.
    if (aux_gnt_s || !aux_pend_s) begin
      cnt_d = '0;
    end else if (gnt_s[0]) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      valid_q  <= '0;
      starve_q <= 1'b0;
      rr_ptr_q <= PTR_W'(1);
      cnt_q    <= '0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      valid_q  <= valid_d;
      starve_q <= starve_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign gnt          = gnt_s;
  assign result       = result_q;
  assign carry_out    = carry_q;
  assign result_valid = valid_q;
  assign starve_event = starve_q;

endmodule

// File: tb/tb_ds_adder_arbiter.sv
// Self-checking bench for ds_adder_arbiter (default parameters); honours DS_ARB_SATURATE_EN.
module tb_ds_adder_arbiter;
  import ds_arb_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        req, inv, gnt, rv;
  logic [3:0][15:0]  s0, s1;
  logic [15:0]       result;
  logic              carry, se;
  int                n_checks = 0;
  int                n_fail = 0;

  int    m_rr, m_cnt;
  word_t m_res;
  logic  m_carry, m_se;
  logic [3:0] m_rv;
  logic [3:0] eg, og;

  always #5 clk = ~clk;

  ds_adder_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .src0(s0), .src1(s1), .inv_src1(inv),
    .gnt(gnt), .result(result), .carry_out(carry), .result_valid(rv),
    .starve_event(se)
  );

  function automatic logic [3:0] model_gnt(input logic [3:0] r);
    logic [3:0] g;
    int k;
    g = 4'b0000;
    if (reset) return g;
    if (r[0] && m_cnt < 7) return 4'b0001;
    for (int i = 0; i < 3; i++) begin
      k = ((m_rr - 1 + i) % 3) + 1;
      if (g == 4'b0000 && r[k]) g[k] = 1'b1;
    end
    return g;
  endfunction

  task automatic model_reset();
    m_rr = 1; m_cnt = 0; m_res = 16'h0000; m_carry = 1'b0; m_rv = 4'b0000; m_se = 1'b0;
  endtask

  task automatic model_commit(input logic [3:0] g);
    int idx;
    longint sum;
    logic inv1;
    logic [15:0] bb;
    m_se = 1'b0;
    m_rv = g;
    if (g == 4'b0000) begin
      if (req[3:1] == 3'b000) m_cnt = 0;
      return;
    end
    idx  = $clog2(g);
    inv1 = inv[idx];
    bb   = inv1 ? ~s1[idx] : s1[idx];
    sum  = longint'(s0[idx]) + longint'(bb) + (inv1 ? 64'd1 : 64'd0);
    m_carry = sum[16];
    m_res   = sum[15:0];
`ifdef DS_ARB_SATURATE_EN
    if (m_carry && !inv1) m_res = 16'hFFFF;
    else if (!m_carry && inv1) m_res = 16'h0000;
`endif
    if (idx == 0) begin
      if (req[3:1] != 3'b000) m_cnt++;
      else m_cnt = 0;
    end else begin
      m_se  = req[0] && (m_cnt >= 7);
      m_cnt = 0;
      m_rr  = (idx == 3) ? 1 : idx + 1;
    end
  endtask

  // One clock: sample combinational grant, update model, cross the edge.
  task automatic advance(output logic [3:0] e, output logic [3:0] o);
    #1;
    e = model_gnt(req);
    o = gnt;
    model_commit(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'hF; inv = 4'h0; s0 = '0; s1 = '0;
    model_reset();
    #2;
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    n_checks++; if ({result, carry, rv, se} !== 22'd0) begin n_fail++;
      $display("FAIL reset_outputs got res=%h c=%b rv=%b se=%b want all 0", result, carry, rv, se); end
    @(posedge clk); #1;
    reset = 1'b0; req = 4'h0;
  endtask

  task automatic test_single_aux();
    req = 4'b0100; s0[2] = 16'h1234; s1[2] = 16'h0011; inv = 4'b0000;
    advance(eg, og);
    n_checks++; if (og !== 4'b0100) begin n_fail++; $display("FAIL aux_add_gnt got %b want 0100", og); end
    n_checks++; if ({result, carry, rv} !== {16'h1245, 1'b0, 4'b0100}) begin n_fail++;
      $display("FAIL aux_add got res=%h c=%b rv=%b want 1245 0 0100", result, carry, rv); end
    req = 4'b0000;
    advance(eg, og);
    n_checks++; if ({result, rv} !== {16'h1245, 4'b0000}) begin n_fail++;
      $display("FAIL idle_hold got res=%h rv=%b want 1245 0000", result, rv); end
  endtask

  task automatic test_subtract_borrow();
    logic [15:0] want;
`ifdef DS_ARB_SATURATE_EN
    want = 16'h0000;
`else
    want = 16'hFFFE;
`endif
    req = 4'b0010; s0[1] = 16'h0005; s1[1] = 16'h0007; inv = 4'b0010;
    advance(eg, og);
    n_checks++; if ({result, carry, rv} !== {want, 1'b0, 4'b0010}) begin n_fail++;
      $display("FAIL sub_borrow got res=%h c=%b rv=%b want %h 0 0010", result, carry, rv, want); end
    req = 4'b0000; inv = 4'b0000;
    advance(eg, og);
  endtask

  task automatic test_overflow();
    logic [15:0] want;
`ifdef DS_ARB_SATURATE_EN
    want = 16'hFFFF;
`else
    want = 16'h0001;
`endif
    req = 4'b1000; s0[3] = 16'hFFFF; s1[3] = 16'h0002; inv = 4'b0000;
    advance(eg, og);
    n_checks++; if ({result, carry, rv} !== {want, 1'b1, 4'b1000}) begin n_fail++;
      $display("FAIL overflow got res=%h c=%b rv=%b want %h 1 1000", result, carry, rv, want); end
    req = 4'b0000;
    advance(eg, og);
  endtask

  task automatic test_round_robin();
    logic [3:0] seq [6];
    seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
    req = 4'b1110;
    for (int i = 0; i < 6; i++) begin
      advance(eg, og);
      n_checks++; if (og !== seq[i] || rv !== seq[i] || se !== 1'b0) begin n_fail++;
        $display("FAIL rr_step%0d got gnt=%b rv=%b se=%b want %b %b 0", i, og, rv, se, seq[i], seq[i]); end
    end
    req = 4'b0000;
    advance(eg, og);
  endtask

  task automatic test_starvation();
    logic [3:0] want;
    req = 4'b0011;
    for (int i = 0; i < 16; i++) begin
      want = (i % 8 == 7) ? 4'b0010 : 4'b0001;
      advance(eg, og);
      n_checks++; if (og !== want || se !== (i % 8 == 7)) begin n_fail++;
        $display("FAIL starve_step%0d got gnt=%b se=%b want %b %b", i, og, se, want, (i % 8 == 7)); end
    end
    req = 4'b0000;
    advance(eg, og);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      req = 4'($urandom_range(0, 15));
      inv = 4'($urandom_range(0, 15));
      for (int p = 0; p < 4; p++) begin
        s0[p] = 16'($urandom);
        s1[p] = 16'($urandom);
      end
      advance(eg, og);
      n_checks++; if (og !== eg) begin n_fail++; $display("FAIL rand_gnt cycle %0d got %b want %b", i, og, eg); end
      n_checks++; if ({result, carry, rv, se} !== {m_res, m_carry, m_rv, m_se}) begin n_fail++;
        $display("FAIL rand_out cycle %0d got res=%h c=%b rv=%b se=%b want %h %b %b %b",
                 i, result, carry, rv, se, m_res, m_carry, m_rv, m_se); end
    end
    req = 4'b0000; inv = 4'b0000;
    advance(eg, og);
  endtask

  task automatic test_async_reset();
    req = 4'b0100; s0[2] = 16'h0001; s1[2] = 16'h0001;
    advance(eg, og);
    req = 4'b0001; s0[0] = 16'h00AA; s1[0] = 16'h0001;
    advance(eg, og);
    n_checks++; if ({result, rv} !== {16'h00AB, 4'b0001}) begin n_fail++;
      $display("FAIL prereset got res=%h rv=%b want 00ab 0001", result, rv); end
    #2;
    reset = 1'b1; req = 4'b0010;
    model_reset();
    #1;
    n_checks++; if ({result, carry, rv, se} !== 22'd0 || gnt !== 4'b0000) begin n_fail++;
      $display("FAIL async_clear got res=%h c=%b rv=%b se=%b gnt=%b want zeros", result, carry, rv, se, gnt); end
    @(posedge clk); #1;
    reset = 1'b0; req = 4'b0000;
    advance(eg, og);
    n_checks++; if (rv !== 4'b0000) begin n_fail++; $display("FAIL post_reset_valid got %b want 0000", rv); end
    req = 4'b1010;
    advance(eg, og);
    n_checks++; if (og !== 4'b0010 || rv !== 4'b0010) begin n_fail++;
      $display("FAIL rr_restart got gnt=%b rv=%b want 0010 0010", og, rv); end
    req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single_aux();
    test_subtract_borrow();
    test_overflow();
    test_round_robin();
    test_starvation();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
